kc_tape_loader: RTL

Sequences OSD tape downloads (TAP and KCC) from the HPS ioctl stream into KC85/4 main memory. It sits between hps_io and the kc854 memory arbiter. During a download it holds the Z80 off the bus, parses the KCC header, and writes payload bytes to RAM through a request/acknowledge port, throttling hps_io with ioctl_wait. On completion it releases the CPU and optionally issues an autostart address.

---
 rtl/kc_tape_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/kc_tape_loader.sv
// KC85/4 tape download sequencer: holds the Z80 off the bus, parses the KCC
// header out of TAP/KCC ioctl streams and writes the program image into RAM.
module kc_tape_loader #(
    parameter logic [7:0] IDX_TAP = 8'd1,
    parameter logic [7:0] IDX_KCC = 8'd2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic        cpu_hold,
    input  logic        cpu_hold_ack,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic        mem_ack,
    input  logic        autostart_en,
    output logic        start_valid,
    output logic [15:0] start_addr,
    output logic        load_busy,
    output logic        load_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_HDR   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_SKIP  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0]  state_r;
    logic        dl_prev_r;
    logic        fmt_tap_r;
    logic [4:0]  sig_cnt_r;
    logic [7:0]  blk_pos_r;
    logic [6:0]  hdr_cnt_r;
    logic [7:0]  argc_r;
    logic [15:0] load_r;
    logic [15:0] end_r;
    logic [15:0] start_r;
    logic [15:0] addr_r;

    logic dl_rise_s;
    logic idx_ok_s;
    logic rx_state_s;
    logic accept_s;
    logic sig_done_s;
    logic payload_s;
    logic in_range_s;
    logic hdr_bad_s;

    assign dl_rise_s  = ioctl_download & ~dl_prev_r;
    assign idx_ok_s   = (ioctl_index == IDX_TAP) | (ioctl_index == IDX_KCC);
    assign rx_state_s = (state_r == ST_HDR) | (state_r == ST_DATA) | (state_r == ST_SKIP);
    assign accept_s   = ioctl_wr & ~ioctl_wait & rx_state_s;
    assign sig_done_s = (sig_cnt_r == 5'd16);
    // TAP: a byte is payload once the signature is gone and it is not a block number
    assign payload_s  = accept_s & (~fmt_tap_r | (sig_done_s & (blk_pos_r != 8'd0)));
    assign in_range_s = (addr_r < end_r);
    assign hdr_bad_s  = (argc_r < 8'd2) | (end_r <= load_r);

    // Previous ioctl_download level for start-edge detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev_r <= 1'b0;
        end else begin
            dl_prev_r <= ioctl_download;
        end
    end

    // TAP framing counters: 16-byte signature, then 129-byte blocks led by a block number
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sig_cnt_r <= 5'd0;
            blk_pos_r <= 8'd0;
        end else if (state_r == ST_IDLE) begin
            sig_cnt_r <= 5'd0;
            blk_pos_r <= 8'd0;
        end else if (accept_s && fmt_tap_r) begin
            if (!sig_done_s) begin
                sig_cnt_r <= sig_cnt_r + 5'd1;
            end else if (blk_pos_r == 8'd128) begin
                blk_pos_r <= 8'd0;
            end else begin
                blk_pos_r <= blk_pos_r + 8'd1;
            end
        end
    end

    // Download sequencer: bus hold, header capture, RAM writes and completion
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            fmt_tap_r   <= 1'b0;
            hdr_cnt_r   <= 7'd0;
            argc_r      <= 8'd0;
            load_r      <= 16'd0;
            end_r       <= 16'd0;
            start_r     <= 16'd0;
            addr_r      <= 16'd0;
            ioctl_wait  <= 1'b0;
            cpu_hold    <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= 16'd0;
            mem_dout    <= 8'd0;
            start_valid <= 1'b0;
            start_addr  <= 16'd0;
            load_busy   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            start_valid <= 1'b0;
            if (ioctl_wr && ioctl_wait) begin
                load_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (dl_rise_s && idx_ok_s) begin
                        state_r    <= ST_HOLD;
                        fmt_tap_r  <= (ioctl_index == IDX_TAP);
                        hdr_cnt_r  <= 7'd0;
                        argc_r     <= 8'd0;
                        cpu_hold   <= 1'b1;
                        load_busy  <= 1'b1;
                        ioctl_wait <= 1'b1;
                        load_err   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!ioctl_download) begin
                        state_r    <= ST_DONE;
                        ioctl_wait <= 1'b0;
                        load_err   <= 1'b1;
                    end else if (cpu_hold_ack) begin
                        state_r    <= ST_HDR;
                        ioctl_wait <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (!ioctl_download) begin
                        state_r  <= ST_DONE;
                        load_err <= 1'b1;
                    end else if (payload_s) begin
                        hdr_cnt_r <= hdr_cnt_r + 7'd1;
                        case (hdr_cnt_r)
                            7'd16:   argc_r        <= ioctl_data;
                            7'd17:   load_r[7:0]   <= ioctl_data;
                            7'd18:   load_r[15:8]  <= ioctl_data;
                            7'd19:   end_r[7:0]    <= ioctl_data;
                            7'd20:   end_r[15:8]   <= ioctl_data;
                            7'd21:   start_r[7:0]  <= ioctl_data;
                            7'd22:   start_r[15:8] <= ioctl_data;
                            default: argc_r        <= argc_r;
                        endcase
                        // Last header byte: all address fields are already captured
                        if (hdr_cnt_r == 7'd127) begin
                            addr_r <= load_r;
                            if (hdr_bad_s) begin
                                state_r  <= ST_SKIP;
                                load_err <= 1'b1;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (!ioctl_download) begin
                        state_r <= ST_DONE;
                    end else if (payload_s && in_range_s) begin
                        state_r    <= ST_WRITE;
                        mem_req    <= 1'b1;
                        mem_addr   <= addr_r;
                        mem_dout   <= ioctl_data;
                        ioctl_wait <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack && mem_req) begin
                        state_r    <= ST_DATA;
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        addr_r     <= addr_r + 16'd1;
                    end
                end
                ST_SKIP: begin
                    if (!ioctl_download) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    cpu_hold   <= 1'b0;
                    load_busy  <= 1'b0;
                    ioctl_wait <= 1'b0;
                    if (!load_err) begin
                        if (addr_r != end_r) begin
                            load_err <= 1'b1;
                        end else if ((argc_r >= 8'd3) && autostart_en) begin
                            start_valid <= 1'b1;
                            start_addr  <= start_r;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cpu_hold   <= 1'b0;
                    load_busy  <= 1'b0;
                    ioctl_wait <= 1'b0;
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule
